// File: rtl/cofre_sequencial.sv
// Parametrised sequential code lock: CODE_LEN digits per attempt, lockout after MAX_FAIL misses.
// Optional macro OPEN_TIMEOUT_EN: OPEN relocks by itself after OPEN_CYCLES idle cycles.
module cofre_sequencial #(
    parameter int                          DIGIT_W        = 4,
    parameter int                          CODE_LEN       = 6,
    parameter logic [DIGIT_W*CODE_LEN-1:0] CODE           = 24'h590981,
    parameter int                          MAX_FAIL       = 3,
    parameter int                          LOCKOUT_CYCLES = 16,
    parameter int                          OPEN_CYCLES    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               insere,
    input  logic [DIGIT_W-1:0] numero,
    output logic               LED,
    output logic               bloqueado,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               D,
    output logic               E,
    output logic               F,
    output logic               G
);

    localparam int IDX_W   = $clog2(CODE_LEN + 1);
    localparam int FC_W    = $clog2(MAX_FAIL + 1);
    localparam int TMR_MAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_F = 7'b1000111;
    localparam logic [6:0] SEG_0 = 7'b1111110;

    typedef enum logic [1:0] {S_ENTRY, S_OPEN, S_FAIL, S_LOCKOUT} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               erro, erro_n;
    logic [FC_W-1:0]    fail_cnt, fail_n, fail_inc;
    logic [TMR_W-1:0]   timer, timer_n;
    logic               mism;
    logic               led_n, blq_n;
    logic [6:0]         seg, seg_n;

    // Code digits unpacked into a table sized to the full idx range so indexing is always in bounds.
    logic [DIGIT_W-1:0] code_tab [2**IDX_W];

    genvar g;
    generate
        for (g = 0; g < 2**IDX_W; g++) begin : g_code
            if (g < CODE_LEN) begin : g_dig
                assign code_tab[g] = CODE[(CODE_LEN-1-g)*DIGIT_W +: DIGIT_W];
            end else begin : g_pad
                assign code_tab[g] = '0;
            end
        end
    endgenerate

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1111110;
            4'h1: hex7 = 7'b0110000;
            4'h2: hex7 = 7'b1101101;
            4'h3: hex7 = 7'b1111001;
            4'h4: hex7 = 7'b0110011;
            4'h5: hex7 = 7'b1011011;
            4'h6: hex7 = 7'b1011111;
            4'h7: hex7 = 7'b1110000;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1111011;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b0011111;
            4'hC: hex7 = 7'b1001110;
            4'hD: hex7 = 7'b0111101;
            4'hE: hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    assign mism     = (numero != code_tab[idx]);
    assign fail_inc = (fail_cnt == FC_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_ENTRY;
            idx      <= '0;
            erro     <= 1'b0;
            fail_cnt <= '0;
            timer    <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            erro     <= erro_n;
            fail_cnt <= fail_n;
            timer    <= timer_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        erro_n  = erro;
        fail_n  = fail_cnt;
        timer_n = timer;
        case (state)
            S_ENTRY: begin
                // Every attempt consumes all digits so a mismatch position is never revealed.
                if (insere) begin
                    if (idx == IDX_W'(CODE_LEN - 1)) begin
                        idx_n   = '0;
                        erro_n  = 1'b0;
                        timer_n = '0;
                        if (!(erro || mism)) begin
                            state_n = S_OPEN;
                            fail_n  = '0;
                        end else begin
                            fail_n  = fail_inc;
                            state_n = (fail_inc == FC_W'(MAX_FAIL)) ? S_LOCKOUT : S_FAIL;
                        end
                    end else begin
                        idx_n  = idx + 1'b1;
                        erro_n = erro | mism;
                    end
                end
            end
            S_OPEN: begin
                if (insere) begin
                    state_n = S_ENTRY;
                    timer_n = '0;
                end
`ifdef OPEN_TIMEOUT_EN
                else if (timer == TMR_W'(OPEN_CYCLES - 1)) begin
                    state_n = S_ENTRY;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
`endif
            end
            S_FAIL: begin
                state_n = S_ENTRY;
            end
            S_LOCKOUT: begin
                if (timer == TMR_W'(LOCKOUT_CYCLES - 1)) begin
                    state_n = S_ENTRY;
                    fail_n  = '0;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n = S_ENTRY;
            end
        endcase
    end

    // Outputs are derived from the next state and registered, so they track state with no extra lag.
    always_comb begin
        led_n = (state_n == S_OPEN);
        blq_n = (state_n == S_LOCKOUT);
        case (state_n)
            S_ENTRY: seg_n = hex7(4'(idx_n));
            S_OPEN:  seg_n = SEG_A;
            default: seg_n = SEG_F;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            LED       <= 1'b0;
            bloqueado <= 1'b0;
            seg       <= SEG_0;
        end else begin
            LED       <= led_n;
            bloqueado <= blq_n;
            seg       <= seg_n;
        end
    end

    assign {A, B, C, D, E, F, G} = seg;

endmodule

// File: tb/tb_cofre_sequencial.sv
// Bench for cofre_sequencial: per-cycle compare against an attempt-level model plus literal spot checks.
module tb_cofre_sequencial;

    localparam int DIGIT_W  = 4;
    localparam int CODE_LEN = 6;
    localparam int MAX_FAIL = 3;
    localparam int LOCK_CYC = 16;
    localparam int OPEN_CYC = 32;

    localparam int M_ENTRY = 0;
    localparam int M_OPEN  = 1;
    localparam int M_FAIL  = 2;
    localparam int M_LOCK  = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               insere;
    logic [DIGIT_W-1:0] numero;
    logic               LED, bloqueado, A, B, C, D, E, F, G;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    int code_d [CODE_LEN] = '{5, 9, 0, 9, 8, 1};
    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int m_mode, m_n, m_fails, m_left, m_age;
    int m_buf [CODE_LEN];

    cofre_sequencial #(
        .DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN), .CODE(24'h590981),
        .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYCLES(LOCK_CYC), .OPEN_CYCLES(OPEN_CYC)
    ) dut (
        .clk(clk), .reset(reset), .insere(insere), .numero(numero),
        .LED(LED), .bloqueado(bloqueado),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G)
    );

    always #5 clk = ~clk;

    function automatic bit attempt_ok(input int last);
        bit ok = 1'b1;
        for (int i = 0; i < CODE_LEN - 1; i++)
            if (m_buf[i] != code_d[i]) ok = 1'b0;
        if (last != code_d[CODE_LEN-1]) ok = 1'b0;
        return ok;
    endfunction

    function automatic int bump(input int f);
        return (f + 1 > MAX_FAIL) ? MAX_FAIL : f + 1;
    endfunction

    // Attempt-level model: buffer digits, judge the whole attempt at its last digit.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode  <= M_ENTRY;
            m_n     <= 0;
            m_fails <= 0;
            m_left  <= 0;
            m_age   <= 0;
        end else begin
            case (m_mode)
                M_ENTRY: if (insere) begin
                    if (m_n == CODE_LEN - 1) begin
                        m_n <= 0;
                        if (attempt_ok(int'(numero))) begin
                            m_mode  <= M_OPEN;
                            m_fails <= 0;
                            m_age   <= 0;
                        end else begin
                            m_fails <= bump(m_fails);
                            m_mode  <= (bump(m_fails) == MAX_FAIL) ? M_LOCK : M_FAIL;
                            m_left  <= LOCK_CYC;
                        end
                    end else begin
                        m_buf[m_n] <= int'(numero);
                        m_n        <= m_n + 1;
                    end
                end
                M_FAIL: m_mode <= M_ENTRY;
                M_OPEN: begin
                    if (insere) m_mode <= M_ENTRY;
`ifdef OPEN_TIMEOUT_EN
                    else if (m_age + 1 == OPEN_CYC) m_mode <= M_ENTRY;
                    else m_age <= m_age + 1;
`endif
                end
                default: begin
                    if (m_left == 1) begin
                        m_mode  <= M_ENTRY;
                        m_fails <= 0;
                    end
                    m_left <= m_left - 1;
                end
            endcase
        end
    end

    function automatic logic [8:0] model_out();
        logic [6:0] s;
        if (m_mode == M_ENTRY)     s = glyph[m_n];
        else if (m_mode == M_OPEN) s = 7'b1110111;
        else                       s = 7'b1000111;
        return {m_mode == M_OPEN, m_mode == M_LOCK, s};
    endfunction

    function automatic logic [8:0] dut_out();
        return {LED, bloqueado, A, B, C, D, E, F, G};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got LED,blq,seg=%b expected %b", name, act, exp);
        end
    endtask

    always begin
        @(negedge clk);
        if (chk_en) check("cycle", dut_out(), model_out());
    end

    task automatic strobe(input int d);
        @(posedge clk); #1;
        insere = 1'b1;
        numero = DIGIT_W'(d);
        @(posedge clk); #1;
        insere = 1'b0;
    endtask

    task automatic send_code(input logic [23:0] c);
        for (int i = 0; i < CODE_LEN; i++) begin
            @(posedge clk); #1;
            insere = 1'b1;
            numero = c[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
        end
        @(posedge clk); #1;
        insere = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; insere = 1'b0; numero = '0;
        #1 reset = 1'b0;
        #20;
        check("reset_state", dut_out(), 9'b0_0_1111110);
        @(posedge clk); #1;
        reset  = 1'b1;
        chk_en = 1'b1;

        // correct code opens, a strobe relocks
        send_code(24'h590981);
        check("open", dut_out(), 9'b1_0_1110111);
        strobe(0);
        check("relock", dut_out(), 9'b0_0_1111110);

        // progress display, then wrong last digit
        strobe(5);
        check("idx1", dut_out(), 9'b0_0_0110000);
        strobe(9); strobe(0); strobe(9); strobe(8);
        check("idx5", dut_out(), 9'b0_0_1011011);
        strobe(7);
        check("fail_cycle", dut_out(), 9'b0_0_1000111);
        @(posedge clk); #1;
        check("after_fail", dut_out(), 9'b0_0_1111110);

        // second wrong attempt; strobe during FAIL is ignored
        send_code(24'h593981);
        check("fail2", dut_out(), 9'b0_0_1000111);
        insere = 1'b1; numero = 4'd5;
        @(posedge clk); #1;
        insere = 1'b0;
        check("fail_ignores", dut_out(), 9'b0_0_1111110);

        // third wrong attempt locks out; strobes during lockout ignored
        send_code(24'h000000);
        check("lockout", dut_out(), 9'b0_1_1000111);
        n = 0;
        insere = 1'b1;
        while (bloqueado && n < 40) begin
            @(posedge clk); #1;
            n++;
            numero = n[3:0];
        end
        insere = 1'b0;
        check("lock_len", 9'(n), 9'(LOCK_CYC));
        check("after_lock", dut_out(), 9'b0_0_1111110);

        // two wrong, one correct, two wrong: no lockout
        send_code(24'h593981);
        send_code(24'h111111);
        send_code(24'h590981);
        check("open2", dut_out(), 9'b1_0_1110111);
        strobe(3);
        send_code(24'h590980);
        send_code(24'h990981);
        check("no_lock", dut_out(), 9'b0_0_1000111);

        // async reset mid-attempt
        strobe(5); strobe(9); strobe(0);
        check("idx3", dut_out(), 9'b0_0_1111001);
        #1 reset = 1'b0;
        #1 check("async_reset", dut_out(), 9'b0_0_1111110);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        send_code(24'h593981);
        send_code(24'h593981);
        check("reset_cleared_fails", dut_out(), 9'b0_0_1000111);

        // open held (or timed out) with no strobes
        send_code(24'h590981);
        check("open3", dut_out(), 9'b1_0_1110111);
        repeat (40) @(posedge clk);
        #1;
`ifdef OPEN_TIMEOUT_EN
        check("open_idle", dut_out(), 9'b0_0_1111110);
`else
        check("open_idle", dut_out(), 9'b1_0_1110111);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
